uart_tx_buffered: RTL
=====================

# uart_tx_buffered

Byte-wide asynchronous serial transmitter, the transmit half of the NES host link. It accepts bytes on a one-cycle strobe interface, buffers them, and shifts them out as 8N1 frames on `UART_TX` at a fixed clocks-per-bit rate, using the same bit timing as the link's receive side. It sits between the host-response logic and the board's serial TX pin.

## Interface
- `CLKS_PER_BIT`, default 10: clock cycles per serial bit; must be ≥ 2.
- `FIFO_DEPTH`, default 16: transmit FIFO entries; power of two, ≥ 2. Ignored when the FIFO is compiled out.
- `clk`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `data`  in  8: byte to transmit, valid when `send` is high.
- `send`  in  1: write strobe; the byte is accepted on a rising edge where `send && ready`.
- `ready`  out  1: buffer can accept a byte this cycle.
- `busy`  out  1: a frame is in progress or the buffer is non-empty.
- `UART_TX`  out  1: serial line output, idle high; driven from a register.

## Operation
- Frame format: start bit (0), then 8 data bits LSB first, then one stop bit (1). Each bit lasts exactly `CLKS_PER_BIT` cycles, so a frame is 10×`CLKS_PER_BIT` cycles.
- FSM states are IDLE, START, DATA and STOP.
  - IDLE → START when the buffer is non-empty: pop one byte into the shift register and drive `UART_TX` low.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA → STOP after 8 bits; a 3-bit index selects the bit.
  - At the end of STOP: if the buffer is non-empty, pop and go to START with no idle gap; otherwise go to IDLE.
- Bit divider: counts down from `CLKS_PER_BIT`−1 to 0. Its width is `$clog2(CLKS_PER_BIT)`, and it wraps by reload, never by overflow.
- FIFO: uses pointers one bit wider than the address.
  - `ready = !full`.
  - Push and pop on the same edge are both honoured, and the count is unchanged.
  - `send` while `!ready` is dropped silently; no state changes.
- `busy = (state != IDLE) || !empty`.
- Reset values: `UART_TX`=1, `ready`=1, `busy`=0, FSM=IDLE, FIFO empty, divider and bit index 0.
- Reset mid-frame: the frame is aborted. `UART_TX` goes high asynchronously, and all buffered bytes are discarded. No partial frame resumes after release.
- `data` is sampled only on the accepting edge; later changes do not affect queued bytes.

## Timing
- Latency: if `send` is accepted at edge k with the FSM in IDLE and the buffer empty, `UART_TX` is low from edge k+1.
- Start bit occupies edges k+1 … k+`CLKS_PER_BIT`. Data bit i begins at edge k+1+(i+1)×`CLKS_PER_BIT`. The stop bit begins at edge k+1+9×`CLKS_PER_BIT`.
- `busy` falls at edge k+1+10×`CLKS_PER_BIT` if nothing else is queued.
- Back-to-back frames: the next start bit begins on the edge immediately after the last stop-bit cycle.
- `ready` is combinational from registered FIFO state. It deasserts on the edge the FIFO becomes full and reasserts on the edge of the pop that frees an entry.

## Configuration
- `UART_TX_FIFO_EN` defined: a `FIFO_DEPTH`-entry FIFO as above.
- `UART_TX_FIFO_EN` undefined: the FIFO is replaced by a single holding register.
  - `ready = !hold_valid`.
  - The FSM pops the holding register exactly as it pops the FIFO, so one byte can wait while another shifts.
  - All frame timing is identical to the FIFO build.

## Test plan
- **Single byte:** `CLKS_PER_BIT`=10, `send` 0x55 at edge k → `UART_TX` low for k+1..k+10, then 1,0,1,0,1,0,1,0 for 10 cycles each, high from k+91; `busy` low at k+101.
- **Burst:** 0x00, 0xFF, 0xA5 on consecutive cycles → three contiguous frames totalling 300 cycles with no high gap between a stop bit and the next start bit; `ready` stays high.
- **Full FIFO:** `FIFO_DEPTH`=16, `send` held high for 18 consecutive cycles with values 0..17 → `ready` low after the 17th accept, byte 17 dropped, exactly 17 frames out carrying 0..16 in order.
- **Reset mid-frame:** assert `reset` during data bit 3 of 0xC3 → `UART_TX`=1, `busy`=0, `ready`=1 immediately. After release, `send` 0x3C → one clean frame of 0x3C only.
- **Loopback:** drive 0x00..0xFF into a bench mid-bit-sampling UART monitor at the same `CLKS_PER_BIT` → all 256 bytes received in order with valid stop bits.
- **Macro off:** `send` A at k, B at k+2, C at k+3 → A transmitted, B held (`ready`=0), C dropped, then B transmitted back-to-back after A.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: buffered 8N1 serial transmitter for the NES host link.
// Bytes arrive on a one-cycle send strobe, wait in a buffer, and are
// shifted out LSB first at CLKS_PER_BIT clocks per bit.
// Build option: define UART_TX_FIFO_EN for a FIFO_DEPTH-entry FIFO;
// otherwise a single holding register buffers one byte while another shifts.
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 10,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       send,
    output logic       ready,
    output logic       busy,
    output logic       UART_TX
);

    localparam int DIV_W = $clog2(CLKS_PER_BIT);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    logic       empty;
    logic [7:0] head;
    logic       push;
    logic       pop;

    // Reject unusable parameter values at elaboration time.
    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_cpb
            $error("uart_tx_buffered: CLKS_PER_BIT must be at least 2");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("uart_tx_buffered: FIFO_DEPTH must be a power of two, at least 2");
        end
    endgenerate

    // A byte is taken whenever the buffer has room; otherwise the strobe is ignored.
    assign push = send && ready;
    // The FSM takes a byte when idle, or at the last stop-bit cycle for a gapless next frame.
    assign pop  = !empty && ((state == IDLE) || ((state == STOP) && (div_cnt == '0)));
    assign busy = (state != IDLE) || !empty;

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;

    // Extra pointer bit tells full from empty when the addresses coincide.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign ready = !full;
    assign head  = mem[rd_ptr[AW-1:0]];

    // Storage array: written on accept, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= data;
        end
    end

    // Pointer update; simultaneous push and pop both advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
`else
    logic       hold_valid;
    logic [7:0] hold_data;

    assign empty = !hold_valid;
    assign ready = !hold_valid;
    assign head  = hold_data;

    // Single holding register; push only when empty, pop only when full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_data  <= 8'h00;
        end else if (push) begin
            hold_valid <= 1'b1;
            hold_data  <= data;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end
`endif

    // Frame sequencer: start bit, 8 data bits LSB first, stop bit; line driven from a register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
            UART_TX <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift   <= head;
                        UART_TX <= 1'b0;
                        div_cnt <= DIV_MAX;
                        state   <= START;
                    end
                end
                START: begin
                    if (div_cnt == '0) begin
                        div_cnt <= DIV_MAX;
                        bit_idx <= 3'd0;
                        UART_TX <= shift[0];
                        state   <= DATA;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (div_cnt == '0) begin
                        div_cnt <= DIV_MAX;
                        if (bit_idx == 3'd7) begin
                            UART_TX <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            UART_TX <= shift[bit_idx + 3'd1];
                        end
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (div_cnt == '0) begin
                        if (pop) begin
                            shift   <= head;
                            UART_TX <= 1'b0;
                            div_cnt <= DIV_MAX;
                            state   <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    UART_TX <= 1'b1;
                end
            endcase
        end
    end

endmodule
